// File: rtl/io_pkg.sv
// Shared definitions for the switch-input controller: default widths and FSM state encodings.
package io_pkg;

  localparam int SW_W_DEF   = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/edge_fall.sv
// Falling-edge detector: pulse is high for the cycle in which "in" drops from 1 to 0.
module edge_fall (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Resets high so a level that is already low after reset never counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b1;
    else     in_q <= in;
  end

  assign pulse = in_q & ~in;

endmodule

// File: rtl/input_ctrl.sv
// CPU input-instruction controller: stalls the CPU until a button press captures the switch bank.
//
// state | meaning
// IDLE  | no input instruction pending; button presses ignored
// WAIT  | input instruction pending, CPU stalled, waiting for a press
// DONE  | one-cycle capture acknowledge, data valid, stall released
module input_ctrl
  import io_pkg::*;
#(
  parameter int SW_W     = SW_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SIGN_EXT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_n,
  input  logic              req,
  input  logic [SW_W-1:0]   sw,
  output logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              stall,
  output logic              waiting,
  output logic [7:0]        count
);

  state_t            state;
  logic              press;
  logic [DATA_W-1:0] sw_ext;

  edge_fall u_edge_fall (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_n),
    .pulse (press)
  );

  always_comb begin
    sw_ext           = '0;
    sw_ext[SW_W-1:0] = sw;
    if (SIGN_EXT != 0) begin
      for (int i = SW_W; i < DATA_W; i++) sw_ext[i] = sw[SW_W-1];
    end
  end

  // Cancel (req low) takes priority over a coincident press in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      count   <= '0;
      ready   <= 1'b0;
      waiting <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state   <= WAIT;
            waiting <= 1'b1;
          end
        end
        WAIT: begin
          if (!req) begin
            state   <= IDLE;
            waiting <= 1'b0;
          end else if (press) begin
            state   <= DONE;
            waiting <= 1'b0;
            ready   <= 1'b1;
            data    <= sw_ext;
            count   <= count + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          waiting <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          waiting <= 1'b0;
        end
      endcase
    end
  end

  assign stall = req && (state != DONE);

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl; zero- and sign-extending instances share one stimulus stream.
module tb_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_n;
  logic        req;
  logic [15:0] sw;

  logic [31:0] data0, data1;
  logic        ready0, ready1, stall0, stall1, waiting0, waiting1;
  logic [7:0]  count0, count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_ctrl #(.SW_W(16), .DATA_W(32), .SIGN_EXT(0)) dut0 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .req(req), .sw(sw),
    .data(data0), .ready(ready0), .stall(stall0), .waiting(waiting0), .count(count0)
  );

  input_ctrl #(.SW_W(16), .DATA_W(32), .SIGN_EXT(1)) dut1 (
    .clk(clk), .rst(rst), .btn_n(btn_n), .req(req), .sw(sw),
    .data(data1), .ready(ready1), .stall(stall1), .waiting(waiting1), .count(count1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_cnt;

    // Reset
    rst = 1'b1; req = 1'b0; btn_n = 1'b1; sw = '0;
    tick();
    req = 1'b1; #1;
    chk("rst_data",    data0,    32'h0);
    chk("rst_count",   count0,   8'h0);
    chk("rst_ready",   ready0,   1'b0);
    chk("rst_waiting", waiting0, 1'b0);
    chk("rst_stall_req1", stall0, 1'b1);
    req = 1'b0; #1;
    chk("rst_stall_req0", stall0, 1'b0);
    tick();
    rst = 1'b0;

    // Basic capture: req from cycle 2, press at cycle 6, ready at cycle 7
    sw = 16'h00A5; req = 1'b1; #1;
    chk("basic_c2_stall",   stall0,   1'b1);
    chk("basic_c2_waiting", waiting0, 1'b0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("basic_wait_waiting", waiting0, 1'b1);
      chk("basic_wait_stall",   stall0,   1'b1);
      chk("basic_wait_ready",   ready0,   1'b0);
    end
    tick();
    btn_n = 1'b0; #1;
    chk("basic_c6_stall", stall0, 1'b1);
    chk("basic_c6_ready", ready0, 1'b0);
    tick();
    chk("basic_c7_ready",   ready0,   1'b1);
    chk("basic_c7_data",    data0,    32'h000000A5);
    chk("basic_c7_data_se", data1,    32'h000000A5);
    chk("basic_c7_count",   count0,   8'd1);
    chk("basic_c7_stall",   stall0,   1'b0);
    chk("basic_c7_stall_se", stall1,  1'b0);
    chk("basic_c7_waiting", waiting0, 1'b0);
    tick();
    req = 1'b0; btn_n = 1'b1; #1;
    chk("basic_c8_ready", ready0, 1'b0);
    chk("basic_c8_count", count0, 8'd1);
    chk("basic_c8_data",  data0,  32'h000000A5);

    // Sign extension
    tick();
    sw = 16'h8001; req = 1'b1; #1;
    tick();
    chk("sext_waiting", waiting0, 1'b1);
    btn_n = 1'b0; #1;
    tick();
    chk("sext_ready",     ready0, 1'b1);
    chk("sext_ready_se",  ready1, 1'b1);
    chk("sext_zero_data", data0,  32'h00008001);
    chk("sext_sign_data", data1,  32'hFFFF8001);
    chk("sext_count",     count0, 8'd2);
    tick();
    req = 1'b0; btn_n = 1'b1; #1;

    // Cancel with no press
    tick();
    sw = 16'h1234; req = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("cancel_waiting", waiting0, 1'b1);
      chk("cancel_ready",   ready0,   1'b0);
    end
    req = 1'b0; #1;
    tick();
    chk("cancel_idle_waiting", waiting0, 1'b0);
    chk("cancel_idle_ready",   ready0,   1'b0);
    chk("cancel_idle_stall",   stall0,   1'b0);
    chk("cancel_data",         data0,    32'h00008001);
    chk("cancel_count",        count0,   8'd2);

    // Cancel coinciding with a press
    req = 1'b1; #1;
    tick();
    chk("cancel2_waiting", waiting0, 1'b1);
    req = 1'b0; btn_n = 1'b0; #1;
    chk("cancel2_stall", stall0, 1'b0);
    tick();
    chk("cancel2_ready",   ready0,   1'b0);
    chk("cancel2_waiting", waiting0, 1'b0);
    chk("cancel2_count",   count0,   8'd2);
    chk("cancel2_data_se", data1,    32'hFFFF8001);
    btn_n = 1'b1; #1;
    tick();

    // Press in IDLE held into the request: no capture until a fresh press
    btn_n = 1'b0; #1;
    tick();
    req = 1'b1; #1;
    tick();
    chk("idlepress_waiting", waiting0, 1'b1);
    tick();
    chk("idlepress_ready", ready0, 1'b0);
    chk("idlepress_count", count0, 8'd2);
    btn_n = 1'b1; sw = 16'h5A5A; #1;
    tick();
    chk("idlepress_rel_ready",   ready0,   1'b0);
    chk("idlepress_rel_waiting", waiting0, 1'b1);
    btn_n = 1'b0; #1;
    tick();
    chk("idlepress_cap_ready", ready0, 1'b1);
    chk("idlepress_cap_count", count0, 8'd3);
    chk("idlepress_cap_data",  data0,  32'h00005A5A);
    chk("idlepress_cap_data_se", data1, 32'h00005A5A);

    // Held button after a capture: req stays high, no second capture
    tick();
    chk("held_idle_ready",   ready0,   1'b0);
    chk("held_idle_waiting", waiting0, 1'b0);
    chk("held_idle_stall",   stall0,   1'b1);
    tick();
    chk("held_wait_waiting", waiting0, 1'b1);
    tick();
    chk("held_wait_ready", ready0, 1'b0);
    chk("held_wait_count", count0, 8'd3);
    req = 1'b0; btn_n = 1'b1; #1;
    tick();
    chk("held_exit_waiting", waiting0, 1'b0);

    // Press in the same cycle req first rises is ignored
    tick();
    req = 1'b1; btn_n = 1'b0; #1;
    chk("samecyc_waiting0", waiting0, 1'b0);
    tick();
    chk("samecyc_waiting1", waiting0, 1'b1);
    chk("samecyc_ready1",   ready0,   1'b0);
    tick();
    chk("samecyc_ready2", ready0, 1'b0);
    chk("samecyc_count",  count0, 8'd3);
    req = 1'b0; btn_n = 1'b1; #1;
    tick();

    // Reset while in WAIT, with a coincident press
    req = 1'b1; #1;
    tick();
    chk("midrst_waiting_before", waiting0, 1'b1);
    rst = 1'b1; btn_n = 1'b0; #1;
    tick();
    chk("midrst_waiting", waiting0, 1'b0);
    chk("midrst_ready",   ready0,   1'b0);
    chk("midrst_count",   count0,   8'd0);
    chk("midrst_count_se", count1,  8'd0);
    chk("midrst_data",    data0,    32'h0);
    chk("midrst_stall",   stall0,   1'b1);
    chk("midrst_waiting_se", waiting1, 1'b0);
    rst = 1'b0; req = 1'b0; btn_n = 1'b1; #1;
    tick();

    // 256 captures: count wraps to zero, one ready pulse each
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      sw = 16'(i); req = 1'b1; #1;
      tick();
      btn_n = 1'b0; #1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      chk("wrap_ready", ready0, 1'b1);
      chk("wrap_count", count0, exp_cnt);
      chk("wrap_data",  data0,  32'(i));
      req = 1'b0; btn_n = 1'b1; #1;
      tick();
      chk("wrap_ready_low", ready0, 1'b0);
    end
    chk("wrap_final_count",    count0, 8'd0);
    chk("wrap_final_count_se", count1, 8'd0);
    chk("wrap_final_data_se",  data1,  32'h000000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
